// File: rtl/apb_tx_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_tx_cfg_sequencer_if
// Description : APB bus bundle between the TX config sequencer (master) and
//               the TX peripheral APB slave port.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_tx_cfg_sequencer_if #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16
);
  logic [ADDRESSWIDTH-1:0] PADDR_o;
  logic [DATAWIDTH-1:0]    PWDATA_o;
  logic                    PWRITE_o;
  logic                    PSELx_o;
  logic                    PENABLE_o;
  logic                    PREADY_i;

  modport master (
    output PADDR_o,
    output PWDATA_o,
    output PWRITE_o,
    output PSELx_o,
    output PENABLE_o,
    input  PREADY_i
  );

  modport slave (
    input  PADDR_o,
    input  PWDATA_o,
    input  PWRITE_o,
    input  PSELx_o,
    input  PENABLE_o,
    output PREADY_i
  );
endinterface
`default_nettype wire

// File: rtl/apb_tx_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : apb_tx_cfg_sequencer
// Description : APB write master that programs the TX peripheral from a single
//               start request: ctrl (0), N data words (2), reg3 (3), reg4 (4),
//               then cmd (1). One transfer at a time, aborts on slave timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_tx_cfg_sequencer #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16,
  parameter int CNT_W        = 7,
  parameter int TIMEOUT      = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 start_i,
  input  logic [DATAWIDTH-1:0] ctrl_i,
  input  logic [DATAWIDTH-1:0] base_i,
  input  logic [CNT_W-1:0]     count_i,
  input  logic [DATAWIDTH-1:0] reg3_i,
  input  logic [DATAWIDTH-1:0] reg4_i,
  input  logic [DATAWIDTH-1:0] cmd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  apb_tx_cfg_sequencer_if.master bus
);

  // Wait counter only needs to reach TIMEOUT-1; the next low cycle aborts.
  localparam int C_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  // Which register of the write sequence the current transfer targets.
  typedef enum logic [2:0] {
    ST_CTRL = 3'd0,
    ST_DATA = 3'd1,
    ST_REG3 = 3'd2,
    ST_REG4 = 3'd3,
    ST_CMD  = 3'd4
  } step_t;

  state_t                  r_state, w_state_nxt;
  step_t                   r_step,  w_step_nxt;
  logic [CNT_W-1:0]        r_k,     w_k_nxt;
  logic [C_WAIT_W-1:0]     r_wait,  w_wait_nxt;
  logic                    r_abort, w_abort_nxt;
  logic [ADDRESSWIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATAWIDTH-1:0]    r_pwdata, w_pwdata_nxt;

  logic [DATAWIDTH-1:0]    r_base;
  logic [CNT_W-1:0]        r_count;
  logic [DATAWIDTH-1:0]    r_reg3;
  logic [DATAWIDTH-1:0]    r_reg4;
  logic [DATAWIDTH-1:0]    r_cmd;

  logic [CNT_W-1:0]        w_k_inc;

  assign w_k_inc = r_k + CNT_W'(1);

  // State, sequence position and bus address/data registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_step   <= ST_CTRL;
      r_k      <= '0;
      r_wait   <= '0;
      r_abort  <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_step   <= w_step_nxt;
      r_k      <= w_k_nxt;
      r_wait   <= w_wait_nxt;
      r_abort  <= w_abort_nxt;
      r_paddr  <= w_paddr_nxt;
      r_pwdata <= w_pwdata_nxt;
    end
  end

  // Capture the configuration once, when a request is accepted in IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_base  <= '0;
      r_count <= '0;
      r_reg3  <= '0;
      r_reg4  <= '0;
      r_cmd   <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_base  <= base_i;
      r_count <= count_i;
      r_reg3  <= reg3_i;
      r_reg4  <= reg4_i;
      r_cmd   <= cmd_i;
    end
  end

  // Next-state logic; address/data are loaded on every entry to SETUP so the
  // bus values are valid in the SETUP cycle and held until the next one.
  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_k_nxt      = r_k;
    w_wait_nxt   = r_wait;
    w_abort_nxt  = r_abort;
    w_paddr_nxt  = r_paddr;
    w_pwdata_nxt = r_pwdata;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt  = S_SETUP;
          w_step_nxt   = ST_CTRL;
          w_k_nxt      = '0;
          w_wait_nxt   = '0;
          w_abort_nxt  = 1'b0;
          w_paddr_nxt  = ADDRESSWIDTH'(0);
          w_pwdata_nxt = ctrl_i;
        end
      end

      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_wait_nxt  = '0;
      end

      S_ACCESS: begin
        if (bus.PREADY_i) begin
          w_state_nxt = S_GAP;
        end else if (r_wait == C_WAIT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_GAP;
          w_abort_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait + C_WAIT_W'(1);
        end
      end

      S_GAP: begin
        if (r_abort || r_step == ST_CMD) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SETUP;
          case (r_step)
            ST_CTRL: begin
              if (r_count == '0) begin
                w_step_nxt   = ST_REG3;
                w_paddr_nxt  = ADDRESSWIDTH'(3);
                w_pwdata_nxt = r_reg3;
              end else begin
                w_step_nxt   = ST_DATA;
                w_k_nxt      = '0;
                w_paddr_nxt  = ADDRESSWIDTH'(2);
                w_pwdata_nxt = r_base;
              end
            end
            ST_DATA: begin
              if (w_k_inc == r_count) begin
                w_step_nxt   = ST_REG3;
                w_paddr_nxt  = ADDRESSWIDTH'(3);
                w_pwdata_nxt = r_reg3;
              end else begin
                w_k_nxt      = w_k_inc;
                w_paddr_nxt  = ADDRESSWIDTH'(2);
                w_pwdata_nxt = r_base + DATAWIDTH'(w_k_inc);
              end
            end
            ST_REG3: begin
              w_step_nxt   = ST_REG4;
              w_paddr_nxt  = ADDRESSWIDTH'(4);
              w_pwdata_nxt = r_reg4;
            end
            ST_REG4: begin
              w_step_nxt   = ST_CMD;
              w_paddr_nxt  = ADDRESSWIDTH'(1);
              w_pwdata_nxt = r_cmd;
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus and status outputs decoded from the registered state.
  always_comb begin
    bus.PSELx_o   = (r_state == S_SETUP) || (r_state == S_ACCESS);
    bus.PENABLE_o = (r_state == S_ACCESS);
    bus.PWRITE_o  = (r_state == S_SETUP) || (r_state == S_ACCESS);
    bus.PADDR_o   = r_paddr;
    bus.PWDATA_o  = r_pwdata;
    busy_o        = (r_state != S_IDLE);
    done_o        = (r_state == S_GAP) && (r_step == ST_CMD) && !r_abort;
    err_o         = (r_state == S_GAP) && r_abort;
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_tx_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_tx_cfg_sequencer
// Description : Self-checking bench for apb_tx_cfg_sequencer. A list-based
//               model derives the expected write list, end cycle and status
//               pulses from the configuration and per-transfer slave waits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_tx_cfg_sequencer;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int CW = 7;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          start_i;
  logic [DW-1:0] ctrl_i, base_i, reg3_i, reg4_i, cmd_i;
  logic [CW-1:0] count_i;
  logic          busy_o, done_o, err_o;

  apb_tx_cfg_sequencer_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus ();

  apb_tx_cfg_sequencer #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .CNT_W(CW), .TIMEOUT(TO)
  ) u_dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .start_i (start_i),
    .ctrl_i  (ctrl_i),
    .base_i  (base_i),
    .count_i (count_i),
    .reg3_i  (reg3_i),
    .reg4_i  (reg4_i),
    .cmd_i   (cmd_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .bus     (bus.master)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_errors = 0;
  int waits [0:255];   // slave wait cycles per transfer index; >= TO means stuck

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_waits();
    for (int i = 0; i < 256; i++) waits[i] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_psel"},    bus.PSELx_o,   0);
    check_eq({tag, "_penable"}, bus.PENABLE_o, 0);
    check_eq({tag, "_pwrite"},  bus.PWRITE_o,  0);
    check_eq({tag, "_paddr"},   bus.PADDR_o,   0);
    check_eq({tag, "_pwdata"},  bus.PWDATA_o,  0);
    check_eq({tag, "_busy"},    busy_o,        0);
    check_eq({tag, "_done"},    done_o,        0);
    check_eq({tag, "_err"},     err_o,         0);
  endtask

  // One start request; rst_at > 0 asserts PRESET at that cycle instead of finishing.
  task automatic run_seq(input logic [DW-1:0] ctrl, input logic [DW-1:0] base,
                         input logic [CW-1:0] cnt, input logic [DW-1:0] reg3,
                         input logic [DW-1:0] reg4, input logic [DW-1:0] cmd,
                         input bit rand_start, input int rst_at);
    int exp_a[$];
    int exp_d[$];
    int act_a[$];
    int act_d[$];
    int n_exp, n_ok, abort_idx, end_cyc, limit, cur, acc, wt;
    int busy_cnt, done_cnt, done_cyc, err_cnt, err_cyc;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    logic [DW-1:0] word;
    bit seen_end;

    // Reference: ordered write list and timing from the per-transfer waits.
    exp_a.push_back(0); exp_d.push_back(int'(ctrl));
    for (int k = 0; k < int'(cnt); k++) begin
      word = base + DW'(k);
      exp_a.push_back(2); exp_d.push_back(int'(word));
    end
    exp_a.push_back(3); exp_d.push_back(int'(reg3));
    exp_a.push_back(4); exp_d.push_back(int'(reg4));
    exp_a.push_back(1); exp_d.push_back(int'(cmd));
    n_exp     = exp_a.size();
    abort_idx = -1;
    end_cyc   = 0;
    for (int t = 0; t < n_exp; t++) begin
      if (waits[t] >= TO) begin
        abort_idx = t;
        end_cyc  += TO + 2;
        break;
      end
      end_cyc += 3 + waits[t];
    end
    n_ok  = (abort_idx >= 0) ? abort_idx : n_exp;
    limit = end_cyc + 50;

    @(negedge PCLK);
    ctrl_i = ctrl; base_i = base; count_i = cnt;
    reg3_i = reg3; reg4_i = reg4; cmd_i = cmd;
    start_i = 1'b1;

    cur = 0; acc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    err_cnt = 0; err_cyc = -1; seen_end = 1'b0;
    last_a = '0; last_d = '0;

    for (int c = 1; c <= limit; c++) begin
      @(negedge PCLK);
      // Scramble the config inputs: they must have been captured at start.
      ctrl_i = DW'($urandom); base_i = DW'($urandom); count_i = CW'($urandom);
      reg3_i = DW'($urandom); reg4_i = DW'($urandom); cmd_i  = DW'($urandom);
      check_eq("pwrite_vs_psel", bus.PWRITE_o, bus.PSELx_o);
      if (bus.PSELx_o && !bus.PENABLE_o) begin
        last_a = bus.PADDR_o;
        last_d = bus.PWDATA_o;
        acc = 0;
        bus.PREADY_i = 1'($urandom);
      end else if (bus.PSELx_o && bus.PENABLE_o) begin
        check_eq("paddr_stable",  bus.PADDR_o,  last_a);
        check_eq("pwdata_stable", bus.PWDATA_o, last_d);
        wt = (cur < 256) ? waits[cur] : 0;
        if (acc >= wt) begin
          bus.PREADY_i = 1'b1;
          act_a.push_back(int'(bus.PADDR_o));
          act_d.push_back(int'(bus.PWDATA_o));
          cur++;
        end else begin
          bus.PREADY_i = 1'b0;
        end
        acc++;
      end else begin
        check_eq("paddr_hold",  bus.PADDR_o,  last_a);
        check_eq("pwdata_hold", bus.PWDATA_o, last_d);
        bus.PREADY_i = 1'($urandom);
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_cyc = c; end
      if (err_o)  begin err_cnt++;  err_cyc  = c; end

      if (rst_at == c) begin
        check_eq("rst_lands_in_access", bus.PENABLE_o, 1);
        start_i = 1'b0;
        PRESET  = 1'b1;
        @(negedge PCLK);
        check_all_zero("mid_reset");
        PRESET = 1'b0;
        return;
      end

      start_i = (rand_start && !done_o && !err_o) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (done_o || err_o) begin
        seen_end = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    check_eq("sequence_ended", seen_end, 1);

    @(negedge PCLK);
    check_eq("busy_after_end", busy_o,      0);
    check_eq("psel_after_end", bus.PSELx_o, 0);
    check_eq("done_after_end", done_o,      0);
    check_eq("err_after_end",  err_o,       0);

    check_eq("n_transfers", act_a.size(), n_ok);
    for (int i = 0; i < n_ok && i < act_a.size(); i++) begin
      check_eq($sformatf("addr[%0d]", i), act_a[i], exp_a[i]);
      check_eq($sformatf("data[%0d]", i), act_d[i], exp_d[i]);
    end
    check_eq("busy_cycles", busy_cnt, end_cyc);
    if (abort_idx < 0) begin
      check_eq("done_pulses", done_cnt, 1);
      check_eq("done_cycle",  done_cyc, end_cyc);
      check_eq("err_pulses",  err_cnt,  0);
    end else begin
      check_eq("done_pulses", done_cnt, 0);
      check_eq("err_pulses",  err_cnt,  1);
      check_eq("err_cycle",   err_cyc,  end_cyc);
    end
  endtask

  initial begin
    int cnt;
    PRESET = 1'b1; start_i = 1'b0; bus.PREADY_i = 1'b0;
    ctrl_i = '0; base_i = '0; count_i = '0; reg3_i = '0; reg4_i = '0; cmd_i = '0;
    clear_waits();
    repeat (3) @(negedge PCLK);
    check_all_zero("reset");
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    check_eq("idle_busy", busy_o, 0);

    // Zero-wait reference sequence (done in cycle 21).
    clear_waits();
    run_seq(16'h0060, 16'h0001, 7'd3, 16'h0008, 16'h0001, 16'h0058, 1'b0, 0);

    // No data words: four transfers, done in cycle 12.
    run_seq(16'h1234, 16'h5555, 7'd0, 16'hA5A5, 16'h5A5A, 16'h00FF, 1'b0, 0);

    // Three wait cycles on the second data write.
    clear_waits(); waits[2] = 3;
    run_seq(16'h0060, 16'h0001, 7'd3, 16'h0008, 16'h0001, 16'h0058, 1'b0, 0);

    // Longest legal wait on the first transfer does not abort.
    clear_waits(); waits[0] = TO - 1;
    run_seq(16'h0001, 16'h0010, 7'd1, 16'h0002, 16'h0003, 16'h0004, 1'b0, 0);

    // Slave stuck on addr 3 (transfer 1 + count) -> timeout abort.
    clear_waits(); waits[3] = 1000;
    run_seq(16'h0060, 16'h0100, 7'd2, 16'h0008, 16'h0001, 16'h0058, 1'b0, 0);

    // Data wrap and ignored start pulses while busy.
    clear_waits();
    run_seq(16'h0007, 16'hFFFE, 7'd3, 16'h0033, 16'h0044, 16'h0011, 1'b1, 0);

    // Reset during the ACCESS of transfer 1, then a full clean run.
    clear_waits();
    run_seq(16'h0060, 16'h0001, 7'd3, 16'h0008, 16'h0001, 16'h0058, 1'b0, 5);
    run_seq(16'h0061, 16'h0200, 7'd2, 16'h0009, 16'h0002, 16'h0059, 1'b0, 0);

    // Randomized configurations and slave wait profiles.
    for (int r = 0; r < 10; r++) begin
      clear_waits();
      cnt = (r == 0) ? 127 : $urandom_range(0, 20);
      for (int t = 0; t < cnt + 4; t++)
        waits[t] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      if ($urandom_range(0, 3) == 0) waits[$urandom_range(0, cnt + 3)] = TO;
      run_seq(DW'($urandom), DW'($urandom), CW'(cnt), DW'($urandom),
              DW'($urandom), DW'($urandom), 1'b1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
`default_nettype wire
